srl16_fifo_ctrl: RTL

Sequencing controller that runs a bank of WIDTH SRL16E cells as a 16-deep shift-register FIFO, plus one output register. Capacity is 17 words. The block drives the shared SRL clock enable and the A3..A0 address and captures the addressed SRL outputs into a first-word-fall-through output register. It sits between a write-side producer and a read-side consumer with valid/enable handshakes. The SRL16E bank lives outside the block, and its D inputs are wired directly from the producer's data.

---
 rtl/srl16_fifo_ctrl_if.sv | 30 +++
 rtl/srl16_fifo_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/srl16_fifo_ctrl_if.sv
// Handshake and SRL16E bank signals between srl16_fifo_ctrl and its producer, consumer and SRL bank.
interface srl16_fifo_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             FLUSH;
  logic             WR_EN;
  logic             FULL;
  logic             SRL_CE;
  logic [3:0]       SRL_A;
  logic [WIDTH-1:0] SRL_Q;
  logic             RD_EN;
  logic [WIDTH-1:0] DOUT;
  logic             DOUT_VALID;
  logic [4:0]       COUNT;
  logic             ALMOST_FULL;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  modport slave (
    input  FLUSH, WR_EN, SRL_Q, RD_EN,
    output FULL, SRL_CE, SRL_A, DOUT, DOUT_VALID, COUNT,
           ALMOST_FULL, OVERFLOW, UNDERFLOW
  );

  modport master (
    output FLUSH, WR_EN, SRL_Q, RD_EN,
    input  FULL, SRL_CE, SRL_A, DOUT, DOUT_VALID, COUNT,
           ALMOST_FULL, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/srl16_fifo_ctrl.sv
// Sequencer running an external SRL16E bank as a 16-deep FIFO with a FWFT output register (17 words).
// Define SRL16_FIFO_STATUS_EN to build ALMOST_FULL / OVERFLOW / UNDERFLOW; otherwise they are tied low.
module srl16_fifo_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned AFULL_LEVEL = 14
) (
  input  logic             CLK,
  input  logic             RST,
  srl16_fifo_ctrl_if.slave bus
);
  localparam int unsigned OCC_W  = 5;
  localparam int unsigned ADDR_W = 4;
  localparam logic [OCC_W-1:0] SRL_DEPTH = OCC_W'(16);

  if (AFULL_LEVEL < 1 || AFULL_LEVEL > 17) begin : g_afull_level_range
    $error("AFULL_LEVEL must lie in 1..17");
  end

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              dout_valid_q, dout_valid_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [ADDR_W-1:0] srl_a_q, srl_a_d;
  logic              full_q, full_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              wr_ok;
  logic              ld;

  // Handshake decode, occupancy and output-register next state
  always_comb begin
    wr_ok        = bus.WR_EN & (occ_q != SRL_DEPTH) & ~bus.FLUSH;
    ld           = (occ_q != '0) & (~dout_valid_q | bus.RD_EN) & ~bus.FLUSH;
    occ_d        = occ_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    if (bus.FLUSH) begin
      occ_d        = '0;
      dout_valid_d = 1'b0;
    end else begin
      if (wr_ok && !ld) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (ld && !wr_ok) begin
        occ_d = occ_q - OCC_W'(1);
      end
      if (ld) begin
        dout_d       = bus.SRL_Q;
        dout_valid_d = 1'b1;
      end else if (bus.RD_EN && dout_valid_q) begin
        dout_valid_d = 1'b0;
      end
    end

    // Address is registered so SRL_Q has a full cycle to settle before the load edge
    srl_a_d = (occ_d == '0) ? '0 : ADDR_W'(occ_d - OCC_W'(1));
    full_d  = (occ_d == SRL_DEPTH);
    count_d = occ_d + OCC_W'(dout_valid_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occ_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      srl_a_q      <= '0;
      full_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      occ_q        <= occ_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      srl_a_q      <= srl_a_d;
      full_q       <= full_d;
      count_q      <= count_d;
    end
  end

  // A write presented while reset is asserted must not shift the bank
  assign bus.SRL_CE     = wr_ok & ~RST;
  assign bus.SRL_A      = srl_a_q;
  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = dout_valid_q;
  assign bus.FULL       = full_q;
  assign bus.COUNT      = count_q;

`ifdef SRL16_FIFO_STATUS_EN
  logic afull_q, afull_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags, cleared only by FLUSH or reset
  always_comb begin
    afull_d = (count_d >= OCC_W'(AFULL_LEVEL));
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.FLUSH) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (bus.WR_EN && (occ_q == SRL_DEPTH)) ovf_d = 1'b1;
      if (bus.RD_EN && !dout_valid_q)        udf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.ALMOST_FULL = afull_q;
  assign bus.OVERFLOW    = ovf_q;
  assign bus.UNDERFLOW   = udf_q;
`else
  assign bus.ALMOST_FULL = 1'b0;
  assign bus.OVERFLOW    = 1'b0;
  assign bus.UNDERFLOW   = 1'b0;
`endif

endmodule
